palette_pixel_pipe: RTL and testbench
=====================================

// Module: palette_pixel_pipe
// PURPOSE
//  Read-side client of the 32x8 PPU palette RAM: converts 5-bit pixel palette indices from the
//  renderer into 24-bit RGB for the VGA path. Shares the RAM's single async read port with
//  CPU $2007 palette reads. Drives the address, takes back the data, and applies backdrop
//  mapping, greyscale and emphasis. Pipelined, one pixel/cycle, with valid/ready on both sides.
// PARAMETERS
//  STALL_LIMIT  4  consecutive cycles a CPU read may lose arbitration before it wins over pixels
//  CH_W         8  bits per RGB channel on rgb_out
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  pix_valid    in   1       pix_idx valid
//  pix_ready    out  1       pixel accepted when pix_valid && pix_ready
//  pix_idx      in   5       [4]=sprite, [3:2]=palette, [1:0]=colour (0 = transparent)
//  mask_grey    in   1       PPUMASK greyscale
//  mask_emph    in   3       PPUMASK emphasis {B,G,R}
//  cpu_rd_req   in   1       CPU palette read request; held until cpu_rd_ack
//  cpu_rd_addr  in   5       CPU palette address (PPU addr[4:0])
//  cpu_rd_ack   out  1       1-cycle pulse: cpu_rd_data valid
//  cpu_rd_data  out  8       {2'b00, colour code}
//  pal_addr     out  5       to palette RAM async read address
//  pal_data     in   8       from palette RAM, same-cycle combinational data
//  rgb_valid    out  1       rgb_out valid
//  rgb_ready    in   1       downstream accepts when rgb_valid && rgb_ready
//  rgb_out      out  3*CH_W  {R,G,B}
// BEHAVIOUR
//  - Reset (async, reset_n=0): s1/s2 valid=0, rgb_valid=0, rgb_out=0, cpu_rd_ack=0,
//    cpu_rd_data=0, starve count=0, pal_addr=0. Reset mid-stream flushes in-flight pixels;
//    an outstanding CPU read gets no ack and the requester must re-issue it.
//  - Address map: pixel with idx[1:0]==0 -> pal_addr 5'h00 (backdrop); else pal_addr=idx.
//    CPU addr 10/14/18/1C -> 00/04/08/0C; other CPU addrs pass through.
//  - Arbitration, one RAM read per cycle:
//    - pixel grant = pix_valid && s1_free && !cpu_win;
//    - cpu_win = cpu_rd_req && (!pix_valid || starve==STALL_LIMIT).
//    - starve increments while cpu_rd_req is pending and loses; it clears on CPU grant.
//    - pix_ready = s1_free && !cpu_win.
//  - CPU read: cpu_rd_data <= {2'b00, pal_data[5:0] & (mask_grey ? 6'h30 : 6'h3F)} at the
//    grant edge. cpu_rd_ack=1 the following cycle only. A req still high in the ack cycle
//    is a new request.
//  - Pixel S1 (grant edge): capture code = pal_data[5:0] masked as above, plus mask_emph.
//    Mask inputs are sampled per pixel, so changes affect only later pixels.
//  - Pixel S2: rgb_out <= lut(code), with optional emphasis; rgb_valid <= 1.
//  - Latency: accept edge -> rgb_valid 2 cycles. Throughput 1 pixel/cycle while
//    rgb_ready=1.
//  - Backpressure: rgb_valid/rgb_out hold stable until taken. s2 loads when empty or taken
//    this cycle. s1_free = !s1_valid || s2 loads.
//  - Full pipe (s1, s2 valid; rgb_ready=0): pix_ready=0 and nothing is lost. A CPU read
//    still proceeds, because it bypasses the pixel stages.
//  - Same-edge events: pixel accept + CPU ack are independent. Both handshakes complete
//    in the same cycle.
// CONFIGURATION
//  PALETTE_EMPHASIS_EN defined: for each set mask_emph bit, the two other channels scale to
//  c - (c>>2). Applies to all codes except the $xE/$xF blacks. The scaling is a registered
//  stage-2 operation, so latency is unchanged.
//  Not defined: mask_emph ignored; rgb_out = lut(code) exactly; no scaling logic built.
// STRUCTURE
//  - Package nes_ppu_pkg: typedef pal_idx_t (5b), nes_color_t (6b), rgb_t (3x CH_W),
//    const PAL_BACKDROP=5'h00, GREY_MASK=6'h30.
//  - Sub-module nes_rgb_lut: 64-entry constant system palette ROM, nes_color_t -> rgb_t,
//    combinational; it is the only natural split.
//  - Arbiter, starve counter and the two pipe stages stay in this file.
// TESTING
//  1 RAM[05]=16, burst idx 05,06,07 with rgb_ready=1
//    -> rgb_out=lut(16),lut(RAM6),lut(RAM7) on 3 consecutive cycles, 2 cycles after accept.
//  2 RAM[00]=0F, RAM[14]=30, pixel idx 14
//    -> pal_addr=00, rgb_out=lut(0F).
//  3 CPU read addr 14 with RAM[04]=2A, pixel stream idle
//    -> pal_addr=04, cpu_rd_ack 1 cycle after grant, cpu_rd_data=2A.
//  4 mask_grey=1, RAM[03]=27, pixel idx 03 then CPU read addr 03
//    -> rgb_out=lut(20), cpu_rd_data=20.
//  5 continuous pix_valid + cpu_rd_req
//    -> CPU granted on 5th cycle (STALL_LIMIT=4), pix_ready=0 that cycle only, no pixel dropped.
//  6 rgb_ready=0 for 10 cycles mid-burst, then reset_n pulse low
//    -> rgb_out stable, pix_ready=0 after 2 accepts, reset clears rgb_valid; no ack follows.

Source files
------------

// File: rtl/nes_ppu_pkg.sv
// Shared types, constants and address/greyscale helpers for the PPU palette read path.
package nes_ppu_pkg;
  localparam int LUT_CH_W = 8;

  typedef logic [4:0]            pal_idx_t;
  typedef logic [5:0]            nes_color_t;
  typedef logic [3*LUT_CH_W-1:0] rgb_t;

  localparam pal_idx_t   PAL_BACKDROP = 5'h00;
  localparam nes_color_t GREY_MASK    = 6'h30;

  // Colour 0 of every palette shows the universal backdrop entry.
  function automatic pal_idx_t pixel_addr(input pal_idx_t idx);
    return (idx[1:0] == 2'b00) ? PAL_BACKDROP : idx;
  endfunction

  // Sprite backdrop slots $10/$14/$18/$1C mirror $00/$04/$08/$0C.
  function automatic pal_idx_t cpu_addr(input pal_idx_t addr);
    return (addr[4] && addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;
  endfunction

  function automatic nes_color_t grey_code(input logic [7:0] data, input logic grey);
    return data[5:0] & (grey ? GREY_MASK : 6'h3F);
  endfunction
endpackage

// File: rtl/nes_rgb_lut.sv
// Constant 64-entry NES system palette: 6-bit colour code to 24-bit {R,G,B}, combinational.
module nes_rgb_lut
  import nes_ppu_pkg::*;
(
  input  nes_color_t code,
  output rgb_t       rgb
);
  always_comb begin
    rgb = '0;
    case (code)
      6'h00: rgb = 24'h7C7C7C; 6'h01: rgb = 24'h0000FC; 6'h02: rgb = 24'h0000BC; 6'h03: rgb = 24'h4428BC;
      6'h04: rgb = 24'h940084; 6'h05: rgb = 24'hA80020; 6'h06: rgb = 24'hA81000; 6'h07: rgb = 24'h881400;
      6'h08: rgb = 24'h503000; 6'h09: rgb = 24'h007800; 6'h0A: rgb = 24'h006800; 6'h0B: rgb = 24'h005800;
      6'h0C: rgb = 24'h004058; 6'h0D: rgb = 24'h000000; 6'h0E: rgb = 24'h000000; 6'h0F: rgb = 24'h000000;
      6'h10: rgb = 24'hBCBCBC; 6'h11: rgb = 24'h0078F8; 6'h12: rgb = 24'h0058F8; 6'h13: rgb = 24'h6844FC;
      6'h14: rgb = 24'hD800CC; 6'h15: rgb = 24'hE40058; 6'h16: rgb = 24'hF83800; 6'h17: rgb = 24'hE45C10;
      6'h18: rgb = 24'hAC7C00; 6'h19: rgb = 24'h00B800; 6'h1A: rgb = 24'h00A800; 6'h1B: rgb = 24'h00A844;
      6'h1C: rgb = 24'h008888; 6'h1D: rgb = 24'h000000; 6'h1E: rgb = 24'h000000; 6'h1F: rgb = 24'h000000;
      6'h20: rgb = 24'hF8F8F8; 6'h21: rgb = 24'h3CBCFC; 6'h22: rgb = 24'h6888FC; 6'h23: rgb = 24'h9878F8;
      6'h24: rgb = 24'hF878F8; 6'h25: rgb = 24'hF85898; 6'h26: rgb = 24'hF87858; 6'h27: rgb = 24'hFCA044;
      6'h28: rgb = 24'hF8B800; 6'h29: rgb = 24'hB8F818; 6'h2A: rgb = 24'h58D854; 6'h2B: rgb = 24'h58F898;
      6'h2C: rgb = 24'h00E8D8; 6'h2D: rgb = 24'h787878; 6'h2E: rgb = 24'h000000; 6'h2F: rgb = 24'h000000;
      6'h30: rgb = 24'hFCFCFC; 6'h31: rgb = 24'hA4E4FC; 6'h32: rgb = 24'hB8B8F8; 6'h33: rgb = 24'hD8B8F8;
      6'h34: rgb = 24'hF8B8F8; 6'h35: rgb = 24'hF8A4C0; 6'h36: rgb = 24'hF0D0B0; 6'h37: rgb = 24'hFCE0A8;
      6'h38: rgb = 24'hF8D878; 6'h39: rgb = 24'hD8F878; 6'h3A: rgb = 24'hB8F8B8; 6'h3B: rgb = 24'hB8F8D8;
      6'h3C: rgb = 24'h00FCFC; 6'h3D: rgb = 24'hF8D8F8; 6'h3E: rgb = 24'h000000; 6'h3F: rgb = 24'h000000;
    endcase
  end
endmodule

// File: rtl/palette_pixel_pipe.sv
// Palette index -> RGB pipeline sharing the palette RAM read port with CPU $2007 reads.
// Define PALETTE_EMPHASIS_EN to build the PPUMASK emphasis scaling into stage 2.
module palette_pixel_pipe
  import nes_ppu_pkg::*;
#(
  parameter int STALL_LIMIT = 4,
  parameter int CH_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [4:0]        pix_idx,
  input  logic              mask_grey,
  input  logic [2:0]        mask_emph,
  input  logic              cpu_rd_req,
  input  logic [4:0]        cpu_rd_addr,
  output logic              cpu_rd_ack,
  output logic [7:0]        cpu_rd_data,
  output logic [4:0]        pal_addr,
  input  logic [7:0]        pal_data,
  output logic              rgb_valid,
  input  logic              rgb_ready,
  output logic [3*CH_W-1:0] rgb_out
);
  localparam int STARVE_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

  logic                s1_valid;
  nes_color_t          s1_code;
  logic [STARVE_W-1:0] starve;
  logic                cpu_win;
  logic                pix_grant;
  logic                s2_load;
  logic                s1_free;
  rgb_t                lut_rgb;
  logic [3*CH_W-1:0]   rgb_next;
`ifdef PALETTE_EMPHASIS_EN
  logic [2:0]          s1_emph;
`else
  logic                unused_emph;
  assign unused_emph = ^mask_emph;
`endif

  // A waiting CPU read only beats a valid pixel once it has lost STALL_LIMIT times in a row.
  assign cpu_win   = cpu_rd_req && (!pix_valid || starve == STARVE_W'(STALL_LIMIT));
  assign s2_load   = !rgb_valid || rgb_ready;
  assign s1_free   = !s1_valid || s2_load;
  assign pix_ready = s1_free && !cpu_win;
  assign pix_grant = pix_valid && pix_ready;

  always_comb begin
    pal_addr = PAL_BACKDROP;
    if (reset_n) begin
      if (cpu_win)
        pal_addr = cpu_addr(cpu_rd_addr);
      else if (pix_grant)
        pal_addr = pixel_addr(pix_idx);
    end
  end

  nes_rgb_lut u_lut (
    .code (s1_code),
    .rgb  (lut_rgb)
  );

  // gi = 0 is blue (low bits), 2 is red; emphasis bit for channel gi is mask_emph[2-gi].
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [CH_W-1:0] base;
    logic [CH_W-1:0] chan;
    if (CH_W >= LUT_CH_W) begin : g_wide
      assign base = CH_W'(lut_rgb[gi*LUT_CH_W +: LUT_CH_W]) << (CH_W - LUT_CH_W);
    end else begin : g_narrow
      assign base = lut_rgb[gi*LUT_CH_W + (LUT_CH_W - CH_W) +: CH_W];
    end
`ifdef PALETTE_EMPHASIS_EN
    logic [2:0]      others;
    logic [CH_W-1:0] once;
    logic [CH_W-1:0] twice;
    assign others = s1_emph & ~3'(1 << (2 - gi));
    assign once   = base - (base >> 2);
    assign twice  = once - (once >> 2);
    always_comb begin
      chan = base;
      if (s1_code[3:1] != 3'b111) begin
        if ($countones(others) == 2)
          chan = twice;
        else if (others != 3'b000)
          chan = once;
      end
    end
`else
    assign chan = base;
`endif
    assign rgb_next[gi*CH_W +: CH_W] = chan;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_code     <= '0;
`ifdef PALETTE_EMPHASIS_EN
      s1_emph     <= '0;
`endif
      rgb_valid   <= 1'b0;
      rgb_out     <= '0;
      cpu_rd_ack  <= 1'b0;
      cpu_rd_data <= '0;
      starve      <= '0;
    end else begin
      cpu_rd_ack <= cpu_win;
      if (cpu_win) begin
        cpu_rd_data <= {2'b00, grey_code(pal_data, mask_grey)};
        starve      <= '0;
      end else if (cpu_rd_req) begin
        starve <= starve + STARVE_W'(1);
      end

      if (pix_grant) begin
        s1_valid <= 1'b1;
        s1_code  <= grey_code(pal_data, mask_grey);
`ifdef PALETTE_EMPHASIS_EN
        s1_emph  <= mask_emph;
`endif
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        rgb_valid <= s1_valid;
        if (s1_valid)
          rgb_out <= rgb_next;
      end
    end
  end
endmodule

// File: tb/tb_palette_pixel_pipe.sv
// Directed bench for palette_pixel_pipe with a behavioural palette/scoreboard model.
module tb_palette_pixel_pipe;
  localparam int STALL_LIMIT = 4;
  localparam int CH_W        = 8;
`ifdef PALETTE_EMPHASIS_EN
  localparam bit EMPH_EN = 1'b1;
`else
  localparam bit EMPH_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              pix_valid, pix_ready;
  logic [4:0]        pix_idx;
  logic              mask_grey;
  logic [2:0]        mask_emph;
  logic              cpu_rd_req;
  logic [4:0]        cpu_rd_addr;
  logic              cpu_rd_ack;
  logic [7:0]        cpu_rd_data;
  logic [4:0]        pal_addr;
  logic [7:0]        pal_data;
  logic              rgb_valid, rgb_ready;
  logic [3*CH_W-1:0] rgb_out;

  always #5 clk = ~clk;

  logic [7:0] ram [32];
  assign pal_data = ram[pal_addr];

  palette_pixel_pipe #(.STALL_LIMIT(STALL_LIMIT), .CH_W(CH_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx),
    .mask_grey(mask_grey), .mask_emph(mask_emph),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_ack(cpu_rd_ack), .cpu_rd_data(cpu_rd_data),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb_valid(rgb_valid), .rgb_ready(rgb_ready), .rgb_out(rgb_out)
  );

  logic [23:0] sys_pal [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  int passes = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Expected RGB for a pixel, from the palette contents and mask state at accept time.
  function automatic logic [23:0] model_rgb(input logic [4:0] idx, input logic grey,
                                            input logic [2:0] emph);
    logic [4:0]  a;
    logic [5:0]  code;
    logic [23:0] p;
    int          ch [3];
    a = (idx[1:0] == 2'b00) ? 5'h00 : idx;
    code = ram[a][5:0];
    if (grey) code = code & 6'h30;
    p = sys_pal[code];
    ch[0] = int'(p[23:16]);
    ch[1] = int'(p[15:8]);
    ch[2] = int'(p[7:0]);
    if (EMPH_EN && code[3:0] < 4'hE)
      for (int b = 0; b < 3; b++)
        if (emph[b])
          for (int c = 0; c < 3; c++)
            if (c != b) ch[c] = ch[c] - ch[c] / 4;
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  function automatic logic [7:0] cpu_model(input logic [4:0] addr, input logic grey);
    logic [4:0] m;
    logic [5:0] c;
    m = addr;
    if (addr == 5'h10 || addr == 5'h14 || addr == 5'h18 || addr == 5'h1C) m = addr - 5'h10;
    c = ram[m][5:0];
    if (grey) c = c & 6'h30;
    return {2'b00, c};
  endfunction

  logic [23:0] exp_q [$];
  logic [7:0]  cpu_exp;
  int          cpu_issued = 0;
  int          cpu_acked = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] held_rgb = '0;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      n_acc = 0;
      n_out = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check1("hold_valid", rgb_valid, 1'b1);
        check("hold_rgb", 32'(rgb_out), 32'(held_rgb));
      end
      stall_prev = rgb_valid && !rgb_ready;
      held_rgb   = rgb_out;
      if (rgb_valid && rgb_ready) begin
        check1("rgb_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("rgb_out", 32'(rgb_out), 32'(exp_q.pop_front()));
        n_out++;
      end
      if (pix_valid && pix_ready) begin
        exp_q.push_back(model_rgb(pix_idx, mask_grey, mask_emph));
        n_acc++;
      end
      if (cpu_rd_ack) begin
        check1("cpu_ack_expected", cpu_issued > cpu_acked, 1'b1);
        if (cpu_issued > cpu_acked) begin
          check("cpu_rd_data", 32'(cpu_rd_data), 32'(cpu_exp));
          cpu_acked++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [4:0] addr, input logic [4:0] exp_pa,
                          input logic [7:0] exp_d, input string tag);
    int lat;
    lat = 0;
    cpu_rd_addr = addr;
    cpu_exp = cpu_model(addr, mask_grey);
    cpu_issued++;
    cpu_rd_req = 1'b1;
    #1;
    check({tag, "_pal_addr"}, 32'(pal_addr), 32'(exp_pa));
    do begin
      tick();
      lat++;
    end while (!cpu_rd_ack && lat < 20);
    cpu_rd_req = 1'b0;
    check({tag, "_ack_latency"}, 32'(lat), 32'd1);
    check({tag, "_data"}, 32'(cpu_rd_data), 32'(exp_d));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    pix_valid = 1'b0;
    rgb_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check1({tag, "_drained"}, exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int   k;
    int   acc;
    logic a;
    logic saw_ack;
    pix_valid = 0; pix_idx = '0; mask_grey = 0; mask_emph = '0;
    cpu_rd_req = 0; cpu_rd_addr = '0; rgb_ready = 1;
    for (int i = 0; i < 32; i++) ram[i] = 8'((i * 7 + 3) & 63);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_rgb_valid", rgb_valid, 1'b0);
    check("rst_rgb_out", 32'(rgb_out), 32'h0);
    check1("rst_cpu_ack", cpu_rd_ack, 1'b0);
    check("rst_cpu_data", 32'(cpu_rd_data), 32'h0);
    check("rst_pal_addr", 32'(pal_addr), 32'h0);
    reset_n = 1;
    tick();

    // 1: burst 05,06,07, two-cycle latency, back-to-back output
    ram[5] = 8'h16; ram[6] = 8'h2A; ram[7] = 8'h30;
    pix_valid = 1; pix_idx = 5'h05;
    #1 check1("t1_ready", pix_ready, 1'b1);
    tick();
    pix_idx = 5'h06;
    check1("t1_latency", rgb_valid, 1'b0);
    tick();
    pix_idx = 5'h07;
    check1("t1_valid0", rgb_valid, 1'b1);
    check("t1_rgb0", 32'(rgb_out), 32'hF83800);
    tick();
    pix_valid = 0;
    check("t1_rgb1", 32'(rgb_out), 32'h58D854);
    tick();
    check("t1_rgb2", 32'(rgb_out), 32'hFCFCFC);
    tick();
    check1("t1_idle", rgb_valid, 1'b0);

    // 2: transparent colour maps to the backdrop entry
    ram[0] = 8'h0F; ram[5'h14] = 8'h30;
    pix_valid = 1; pix_idx = 5'h14;
    #1 check("t2_pal_addr", 32'(pal_addr), 32'h00);
    tick();
    pix_valid = 0;
    tick();
    check1("t2_valid", rgb_valid, 1'b1);
    check("t2_rgb", 32'(rgb_out), 32'h000000);
    tick();

    // 3: CPU read of a mirrored sprite backdrop
    ram[4] = 8'h2A;
    cpu_read(5'h14, 5'h04, 8'h2A, "t3");
    tick();
    check1("t3_ack_pulse", cpu_rd_ack, 1'b0);

    // 4: greyscale on pixel and CPU paths
    mask_grey = 1; ram[3] = 8'h27;
    pix_valid = 1; pix_idx = 5'h03;
    tick();
    pix_valid = 0;
    tick();
    check("t4_rgb", 32'(rgb_out), 32'hF8F8F8);
    cpu_read(5'h03, 5'h03, 8'h20, "t4");
    mask_grey = 0;
    tick();

    // 5: starving CPU read wins on the fifth cycle
    mask_emph = 3'b101;
    k = 0;
    pix_valid = 1; pix_idx = 5'h01;
    cpu_rd_addr = 5'h01; cpu_exp = cpu_model(5'h01, mask_grey); cpu_issued++;
    cpu_rd_req = 1;
    for (int c = 1; c <= 8; c++) begin
      #1;
      check1("t5_pix_ready", pix_ready, c != 5);
      a = pix_ready;
      tick();
      if (c == 5) begin
        check1("t5_cpu_ack", cpu_rd_ack, 1'b1);
        cpu_rd_req = 0;
      end
      if (a) begin
        k++;
        pix_idx = 5'(k * 3 + 1);
      end
    end
    check("t5_accepts", 32'(k), 32'd7);
    drain("t5");
    mask_emph = '0;
    tick();

    // 6: backpressure fills the pipe, CPU still served, then reset mid-stream
    rgb_ready = 0; pix_valid = 1; acc = 0; saw_ack = 0;
    for (int c = 1; c <= 10; c++) begin
      pix_idx = 5'(9 + acc);
      if (c == 3 || c == 9) begin
        cpu_rd_addr = (c == 3) ? 5'h1C : 5'h02;
        cpu_exp = cpu_model(cpu_rd_addr, mask_grey);
        cpu_issued++;
        cpu_rd_req = 1;
      end
      #1;
      check1("t6_pix_ready", pix_ready, c <= 2);
      acc += int'(pix_ready);
      tick();
      if (cpu_rd_ack) begin
        saw_ack = 1;
        cpu_rd_req = 0;
      end
    end
    check("t6_accepts", 32'(acc), 32'd2);
    check1("t6_cpu_served", saw_ack, 1'b1);
    reset_n = 0;
    #1;
    check1("t6_rst_valid", rgb_valid, 1'b0);
    check("t6_rst_rgb", 32'(rgb_out), 32'h0);
    check1("t6_rst_ack", cpu_rd_ack, 1'b0);
    check("t6_rst_data", 32'(cpu_rd_data), 32'h0);
    check("t6_rst_pal_addr", 32'(pal_addr), 32'h0);
    pix_valid = 0; cpu_rd_req = 0; rgb_ready = 1;
    cpu_issued = cpu_acked;
    tick();
    tick();
    reset_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check1("t6_no_ack", cpu_rd_ack, 1'b0);
      check1("t6_flushed", rgb_valid, 1'b0);
    end

    // Pipe runs normally after reset
    pix_valid = 1;
    for (int c = 0; c < 3; c++) begin
      pix_idx = 5'(5'h11 + c);
      tick();
    end
    drain("post");
    check("final_in_out", 32'(n_out), 32'(n_acc));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
